multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath. It replaces per-instruction single-cycle decode with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives the same datapath control set (alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg, alu_op), plus PC/IR write enables.
- It handshakes with instruction and data memories and counts retired instructions.

---
 rtl/multicycle_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_opcode_class_dec.sv | 24 ++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN (adds the HALT state).
package ctrl_pkg;

    // RV32I major opcodes recognised by the sequencer
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    // Sequencer states; encodings are visible on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,ST_HALT  = 3'd5
`endif
    } state_e;

    // Instruction class; ILLEGAL is zero so a cleared register reads as "no class"
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BR      = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_JALR    = 3'd7
    } cls_e;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_JMP = 2'b11;

    // Register-file write-back source select
    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_JAL  = 2'b10;
    localparam logic [1:0] M2R_JALR = 2'b11;

    // True for classes that take the data-memory step
    function automatic logic cls_uses_mem(input cls_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_class_dec.sv
// Combinational opcode -> instruction class decoder used in DECODE.
module opcode_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_e       cls
);

    // Map the seven supported major opcodes; everything else is illegal
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_R:     cls = CLS_R;
            OPC_I:     cls = CLS_I;
            OPC_LOAD:  cls = CLS_LOAD;
            OPC_STORE: cls = CLS_STORE;
            OPC_BR:    cls = CLS_BR;
            OPC_JAL:   cls = CLS_JAL;
            OPC_JALR:  cls = CLS_JALR;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes and a retired-instruction counter.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN -- illegal opcodes park
// the sequencer in HALT (exposed on the `illegal` port) instead of acting as NOPs.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             instr_done,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    cls_e             class_q, class_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    cls_e             dec_cls_s;
    logic             retire_s;

    opcode_class_dec u_dec (
        .opcode (opcode),
        .cls    (dec_cls_s)
    );

    // Next-state and control decode; all controls forced low while in reset
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        retire_s   = 1'b0;
        state      = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = M2R_ALU;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        if (reset) begin
            state   = ST_FETCH;
            state_d = ST_FETCH;
            class_d = CLS_ILLEGAL;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else begin
                        state_d  = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    // opcode is only looked at here; later changes are ignored
                    class_d = dec_cls_s;
                    if (dec_cls_s == CLS_ILLEGAL) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        state_d  = ST_HALT;
`else
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
`endif
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (class_q)
                        CLS_R:     begin alu_src = 1'b0; alu_op = ALU_R;   end
                        CLS_BR:    begin alu_src = 1'b0; alu_op = ALU_BR;  branch = 1'b1; end
                        CLS_JAL:   begin alu_src = 1'b0; alu_op = ALU_JMP; branch = 1'b1; end
                        CLS_JALR:  begin alu_src = 1'b1; alu_op = ALU_JMP; branch = 1'b1; end
                        CLS_I, CLS_LOAD, CLS_STORE: begin alu_src = 1'b1; alu_op = ALU_ADD; end
                        default:   begin alu_src = 1'b0; alu_op = ALU_ADD; end
                    endcase
                    if (cls_uses_mem(class_q)) begin
                        state_d = ST_MEM;
                    end else if (class_q == CLS_BR) begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    alu_src = 1'b1;
                    alu_op  = ALU_ADD;
                    if (class_q == CLS_LOAD) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = (class_q == CLS_STORE);
                    end
                    if (!dmem_ready) begin
                        state_d = ST_MEM;
                    end else if (class_q == CLS_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    case (class_q)
                        CLS_LOAD: mem_to_reg = M2R_MEM;
                        CLS_JAL:  mem_to_reg = M2R_JAL;
                        CLS_JALR: mem_to_reg = M2R_JALR;
                        default:  mem_to_reg = M2R_ALU;
                    endcase
                    state_d  = ST_FETCH;
                    retire_s = 1'b1;
                end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                ST_HALT: begin
                    illegal = 1'b1;
                    state_d = ST_HALT;
                end
`endif
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Retire pulse and counter view; counter reads zero while in reset
    always_comb begin
        instr_done = retire_s;
        instret_d  = instret_q;
        if (reset) begin
            instret = {CNT_W{1'b0}};
        end else begin
            instret = instret_q;
            if (retire_s) begin
                instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                instret_d = instret_q;
            end
        end
    end

    // Sequencer state, latched class and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_ILLEGAL;
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction cycle-table
// model derived from the instruction-class rules, random memory waits and
// random don't-care inputs. A 4-bit counter makes instret wrap quickly.
module tb_multicycle_ctrl;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [6:0]          opcode;
    logic                imem_ready;
    logic                dmem_ready;
    logic [2:0]          state;
    logic                ir_write, pc_write, alu_src, branch;
    logic [1:0]          alu_op, mem_to_reg;
    logic                mem_read, mem_write, reg_write, instr_done;
    logic [TB_CNT_W-1:0] instret;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic                illegal;
`endif

    multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .state      (state),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Observed control vector:
    // {state, ir_write, pc_write, alu_src, alu_op, branch, mem_read, mem_write, reg_write, mem_to_reg, instr_done}
    logic [14:0] obs;
    assign obs = {state, ir_write, pc_write, alu_src, alu_op, branch,
                  mem_read, mem_write, reg_write, mem_to_reg, instr_done};

    typedef struct packed {
        logic [6:0]  opc;
        logic        imem;
        logic        dmem;
        logic [14:0] exp;
    } row_t;

    row_t                q[$];
    row_t                r;
    int                  checks = 0;
    int                  errors = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;

    function automatic logic [6:0] rnd7();
        logic [31:0] t;
        t = $urandom;
        return t[6:0];
    endfunction

    function automatic logic rnd1();
        logic [31:0] t;
        t = $urandom;
        return t[0];
    endfunction

    function automatic logic [14:0] mk(input logic [2:0] st, input logic irw, input logic pcw,
                                       input logic asrc, input logic [1:0] aop, input logic br,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic [1:0] m2r, input logic done);
        return {st, irw, pcw, asrc, aop, br, mr, mw, rw, m2r, done};
    endfunction

    // 0 R, 1 I, 2 LOAD, 3 STORE, 4 BR, 5 JAL, 6 JALR, 7 illegal
    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            default:    return 7;
        endcase
    endfunction

    // Append the expected cycle-by-cycle behaviour of one instruction
    task automatic add_instr(input logic [6:0] opc, input int wi, input int wd);
        int       k;
        logic     asrc, br, done;
        logic [1:0] aop, m2r;
        k = cls_of(opc);
        for (int i = 0; i < wi; i++)
            q.push_back('{rnd7(), 1'b0, rnd1(), 15'd0});
        q.push_back('{rnd7(), 1'b1, rnd1(), mk(3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0)});
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        q.push_back('{opc, rnd1(), rnd1(), mk(3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0)});
        if (k == 7) return;
`else
        q.push_back('{opc, rnd1(), rnd1(), mk(3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, k == 7)});
        if (k == 7) return;
`endif
        asrc = (k == 1) || (k == 2) || (k == 3) || (k == 6);
        aop  = (k == 0) ? 2'b10 : (k == 4) ? 2'b01 : (k >= 5) ? 2'b11 : 2'b00;
        br   = (k >= 4);
        q.push_back('{rnd7(), rnd1(), rnd1(), mk(3'd2, 1'b0, 1'b0, asrc, aop, br, 1'b0, 1'b0, 1'b0, 2'b00, k == 4)});
        if (k == 2 || k == 3) begin
            for (int i = 0; i <= wd; i++) begin
                done = (i == wd) && (k == 3);
                q.push_back('{rnd7(), rnd1(), i == wd,
                              mk(3'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, k == 2, k == 3, 1'b0, 2'b00, done)});
            end
        end
        if (k != 3 && k != 4) begin
            m2r = (k == 2) ? 2'b01 : (k == 5) ? 2'b10 : (k == 6) ? 2'b11 : 2'b00;
            q.push_back('{rnd7(), rnd1(), rnd1(), mk(3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, m2r, 1'b1)});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = rnd7(); #1;
            checks++; if (obs !== 15'd0) begin errors++; $display("FAIL reset_init_ctrl got %b exp %b", obs, 15'd0); end
            checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_init_instret got %0d exp 0", instret); end
        end
        @(negedge clk); reset = 1'b0;
        // retire one R-type so the counter is non-zero, then stop a LOAD inside MEM
        add_instr(7'b0110011, 0, 0);
        add_instr(7'b0000011, 0, 3);
        for (int n = 0; n < 8; n++) begin
            r = q.pop_front();
            if (n > 0) @(negedge clk);
            opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL reset_pre_ctrl row %0d got %b exp %b", n, obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL reset_pre_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) exp_cnt++;
        end
        q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); reset = 1'b1; dmem_ready = (i == 2); imem_ready = 1'b1; #1;
            checks++; if (obs !== 15'd0) begin errors++; $display("FAIL reset_mid_ctrl got %b exp %b", obs, 15'd0); end
            checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_mid_instret got %0d exp 0", instret); end
        end
        exp_cnt = '0;
        @(negedge clk); reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b1; #1;
        checks++; if (obs !== 15'd0) begin errors++; $display("FAIL reset_release_ctrl got %b exp %b", obs, 15'd0); end
        checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_release_instret got %0d exp 0", instret); end
    endtask

    task automatic test_r_type();
        add_instr(7'b0110011, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk); opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL r_type_ctrl got %b exp %b", obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL r_type_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) exp_cnt++;
        end
    endtask

    task automatic test_load_wait();
        int cyc = 0;
        add_instr(7'b0000011, 0, 2);
        while (q.size() > 0) begin
            r = q.pop_front(); cyc++;
            @(negedge clk); opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL load_wait_ctrl cyc %0d got %b exp %b", cyc, obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL load_wait_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) begin
                exp_cnt++;
                checks++; if (cyc != 7) begin errors++; $display("FAIL load_wait_latency got %0d exp 7", cyc); end
            end
        end
    endtask

    task automatic test_back_to_back();
        add_instr(7'b0100011, 0, 0);
        add_instr(7'b1100011, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk); opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL b2b_ctrl got %b exp %b", obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL b2b_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) exp_cnt++;
        end
    endtask

    task automatic test_jalr();
        add_instr(7'b1100111, 1, 0);
        add_instr(7'b1101111, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk); opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL jump_ctrl got %b exp %b", obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL jump_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) exp_cnt++;
        end
    endtask

    task automatic test_illegal();
        add_instr(7'b1111111, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk); opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL illegal_ctrl got %b exp %b", obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL illegal_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) exp_cnt++;
        end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); opcode = rnd7(); imem_ready = rnd1(); dmem_ready = rnd1(); #1;
            checks++; if (obs !== mk(3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0)) begin
                errors++; $display("FAIL halt_ctrl got %b exp state 5 strobes 0", obs); end
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL halt_illegal got %b exp 1", illegal); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL halt_instret got %0d exp %0d", instret, exp_cnt); end
        end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL halt_reset_illegal got %b exp 0", illegal); end
        @(negedge clk); reset = 1'b0;
        exp_cnt = '0;
`endif
    endtask

    task automatic test_random();
        logic [6:0] opc;
        int         pick;
        for (int n = 0; n < 40; n++) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            pick = $urandom_range(6, 0);
`else
            pick = $urandom_range(7, 0);
`endif
            case (pick)
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                2: opc = 7'b0000011;
                3: opc = 7'b0100011;
                4: opc = 7'b1100011;
                5: opc = 7'b1101111;
                6: opc = 7'b1100111;
                default: begin
                    opc = rnd7();
                    if (cls_of(opc) != 7) opc = 7'b0000000;
                end
            endcase
            add_instr(opc, $urandom_range(2, 0), $urandom_range(2, 0));
        end
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk); opcode = r.opc; imem_ready = r.imem; dmem_ready = r.dmem; #1;
            checks++; if (obs !== r.exp) begin errors++; $display("FAIL random_ctrl opc %b got %b exp %b", r.opc, obs, r.exp); end
            checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL random_instret got %0d exp %0d", instret, exp_cnt); end
            if (r.exp[0]) exp_cnt++;
        end
        @(negedge clk); imem_ready = 1'b0; #1;
        checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL random_final_instret got %0d exp %0d", instret, exp_cnt); end
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_back_to_back();
        test_jalr();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
